// File: rtl/csa_accum_pkg.sv
// csa_accum_pkg: shared state encoding and derived constants for csa_accum
package csa_accum_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;
  function automatic int nch(input int acc_width, input int chunk);
    return acc_width / chunk;
  endfunction
endpackage

// File: rtl/csa_accum_if.sv
// csa_accum_if: beat input channel and result output channel of csa_accum
interface csa_accum_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [3:0]           in_en;
  logic [IN_WIDTH-1:0]  in_w;
  logic [IN_WIDTH-1:0]  in_x;
  logic [IN_WIDTH-1:0]  in_y;
  logic [IN_WIDTH-1:0]  in_z;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovfl;
  logic [CNT_W-1:0]     out_count;
  modport master (
    output in_valid, in_last, in_en, in_w, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_sum, out_ovfl, out_count
  );
  modport slave (
    input  in_valid, in_last, in_en, in_w, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_sum, out_ovfl, out_count
  );
endinterface

// File: rtl/csa_accum_csa42_slice.sv
// csa42_slice: word-wide 4:2 compressor (carry-in 0) built from two 3:2 levels
module csa42_slice #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] c_o,
  output logic         ovf_o
);
  logic [W-1:0] s0, m0, c0, m1;
  always_comb begin
    s0    = a_i ^ b_i ^ c_i;
    m0    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    c0    = m0 << 1;
    s_o   = s0 ^ c0 ^ d_i;
    m1    = (s0 & c0) | (s0 & d_i) | (c0 & d_i);
    c_o   = m1 << 1;
    // top majority bits would land at weight 2^W and are dropped
    ovf_o = m0[W-1] | m1[W-1];
  end
endmodule

// File: rtl/csa_accum.sv
// csa_accum: carry-save multi-operand accumulator with chunked carry-propagate resolve
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CHUNK     = 8,
  parameter int CNT_W     = 16
) (
  input logic       clk,
  input logic       rst,
  csa_accum_if.slave bus
);
  localparam int NCH = nch(ACC_WIDTH, CHUNK);
  localparam int KW  = NCH > 1 ? $clog2(NCH) : 1;
  if (ACC_WIDTH % CHUNK != 0) begin : g_chunk_chk
    $error("csa_accum: ACC_WIDTH must be a multiple of CHUNK");
  end
  if (ACC_WIDTH < IN_WIDTH) begin : g_width_chk
    $error("csa_accum: ACC_WIDTH must be >= IN_WIDTH");
  end
  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d, c_q, c_d, res_q, res_d;
  logic [ACC_WIDTH-1:0] ow, ox, oy, oz, s1, c1, s2, c2;
  logic                 ovfl_q, ovfl_d, rc_q, rc_d, ov1, ov2;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CHUNK:0]       csum;
  assign ow = bus.in_en[0] ? ACC_WIDTH'(bus.in_w) : '0;
  assign ox = bus.in_en[1] ? ACC_WIDTH'(bus.in_x) : '0;
  assign oy = bus.in_en[2] ? ACC_WIDTH'(bus.in_y) : '0;
  assign oz = bus.in_en[3] ? ACC_WIDTH'(bus.in_z) : '0;
  csa42_slice #(.W(ACC_WIDTH)) u_stage1 (
    .a_i(ow), .b_i(ox), .c_i(oy), .d_i(oz), .s_o(s1), .c_o(c1), .ovf_o(ov1)
  );
  csa42_slice #(.W(ACC_WIDTH)) u_stage2 (
    .a_i(s_q), .b_i(c_q), .c_i(s1), .d_i(c1), .s_o(s2), .c_o(c2), .ovf_o(ov2)
  );
  assign csum = {1'b0, s_q[int'(k_q)*CHUNK +: CHUNK]} + {1'b0, c_q[int'(k_q)*CHUNK +: CHUNK]}
              + (CHUNK+1)'(rc_q);
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    ovfl_d  = ovfl_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      ACCUM: if (bus.in_valid) begin
        s_d    = s2;
        c_d    = c2;
        ovfl_d = ovfl_q | ov1 | ov2;
        cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (bus.in_last) begin
          state_d = RESOLVE;
          k_d     = '0;
          rc_d    = 1'b0;
        end
      end
      RESOLVE: begin
        res_d[int'(k_q)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        rc_d = csum[CHUNK];
        if (k_q == KW'(NCH-1)) begin
          state_d = OUTPUT;
          ovfl_d  = ovfl_q | csum[CHUNK];
          rc_d    = 1'b0;
        end else k_d = k_q + 1'b1;
      end
      OUTPUT: if (bus.out_ready) begin
        state_d = ACCUM;
        s_d     = '0;
        c_d     = '0;
        res_d   = '0;
        ovfl_d  = 1'b0;
        cnt_d   = '0;
        k_d     = '0;
      end
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      ovfl_q  <= 1'b0;
      rc_q    <= 1'b0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      ovfl_q  <= ovfl_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end
  assign bus.in_ready  = state_q == ACCUM;
  assign bus.out_valid = state_q == OUTPUT;
  assign bus.out_sum   = res_q;
  assign bus.out_ovfl  = ovfl_q;
  assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: directed vectors with a queue scoreboard and a handshake monitor
module tb_csa_accum;
  typedef struct packed {
    logic [23:0] sum;
    logic        ovfl;
    logic [15:0] count;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  csa_accum_if #(.IN_WIDTH(16), .ACC_WIDTH(24), .CNT_W(16)) bus ();
  csa_accum #(.IN_WIDTH(16), .ACC_WIDTH(24), .CHUNK(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("sb_unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sum", 32'(bus.out_sum), 32'(e.sum));
        check("out_ovfl", 32'(bus.out_ovfl), 32'(e.ovfl));
        check("out_count", 32'(bus.out_count), 32'(e.count));
      end
    end
  end
  task automatic push(input logic [23:0] s, input logic o, input logic [15:0] c);
    sb.push_back('{sum: s, ovfl: o, count: c});
  endtask
  task automatic beat(input logic [3:0] en, input logic [15:0] w, x, y, z, input logic last);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g == 50) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_en    = en;
    bus.in_w     = w;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_z     = z;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic wait_result();
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
      check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [23:0] h_sum;
    logic        h_ovfl;
    logic [15:0] h_cnt;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_en     = 4'h0;
    bus.in_w      = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_ovfl", 32'(bus.out_ovfl), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    // single beat, all lanes
    push(24'd10, 1'b0, 16'd1);
    beat(4'hF, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    wait_result();
    // lane mask keeps w and y only
    push(24'd40, 1'b0, 16'd1);
    beat(4'b0101, 16'd10, 16'd20, 16'd30, 16'd40, 1'b1);
    wait_result();
    // 1024 * 0xFFFF wraps with overflow
    push(24'hFFFC00, 1'b1, 16'd256);
    for (int i = 0; i < 256; i++)
      beat(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, i == 255);
    wait_result();
    // total lands exactly on 2^24
    push(24'h000000, 1'b1, 16'd257);
    for (int i = 0; i < 256; i++)
      beat(4'b0001, 16'hFFFF, 16'h0, 16'h0, 16'h0, 1'b0);
    beat(4'b0011, 16'h00FF, 16'h0001, 16'h0, 16'h0, 1'b1);
    wait_result();
    // backpressure: hold result, ignore input
    bus.out_ready = 1'b0;
    push(24'h000579, 1'b0, 16'd1);
    beat(4'b0011, 16'h0123, 16'h0456, 16'h0, 16'h0, 1'b1);
    wait_result();
    h_sum  = bus.out_sum;
    h_ovfl = bus.out_ovfl;
    h_cnt  = bus.out_count;
    check("bp_held_sum", 32'(h_sum), 32'h579);
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_en    = 4'hF;
    bus.in_w     = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum", 32'(bus.out_sum), 32'(h_sum));
      check("bp_ovfl", 32'(bus.out_ovfl), 32'(h_ovfl));
      check("bp_count", 32'(bus.out_count), 32'(h_cnt));
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
    push(24'd7, 1'b0, 16'd1);
    beat(4'b0001, 16'd7, 16'h0, 16'h0, 16'h0, 1'b1);
    wait_result();
    // reset during the second resolve cycle discards the packet
    beat(4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_count", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(24'd5, 1'b0, 16'd1);
    beat(4'b0001, 16'd5, 16'h0, 16'h0, 16'h0, 1'b1);
    wait_result();
    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
